// File: rtl/word_packer.sv
// word_packer: assembles a valid/ready byte stream into 32-bit words.
// Every four accepted bytes form one word; a flush emits a partial,
// zero-padded word together with its valid byte count.
module word_packer #(
  parameter int BIG_ENDIAN = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [2:0]       out_bytes,
  output logic [CNT_W-1:0] word_count
);

  logic [31:0]      wbuf_q, wbuf_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_bytes_q, out_bytes_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic             hs;
  logic             byte_acc;
  logic             flush_acc;
  logic             stall;
  logic [2:0]       cnt_after;
  logic             emit;

  // Place byte b into the lane selected by its arrival index.
  function automatic logic [31:0] place_byte(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] r;
    int          lane;
    r    = w;
    lane = (BIG_ENDIAN != 0) ? (3 - int'(idx)) : int'(idx);
    r[lane*8 +: 8] = b;
    return r;
  endfunction

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_word   = wbuf_q;
  assign out_bytes  = out_bytes_q;
  assign word_count = word_count_q;

  // Next-state: handshake clears the buffer first, then the incoming byte
  // lands in its lane; a completed word or a non-empty flush raises out_valid.
  always_comb begin
    hs        = out_valid_q && out_ready;
    stall     = out_valid_q && !out_ready;
    byte_acc  = in_valid && in_ready;
    flush_acc = flush && in_ready;
    cnt_after = {1'b0, cnt_q} + {2'b00, byte_acc};
    emit      = (cnt_after == 3'd4) || (flush_acc && (cnt_after != 3'd0));

    wbuf_d = hs ? 32'd0 : wbuf_q;
    if (byte_acc) begin
      wbuf_d = place_byte(wbuf_d, cnt_q, in_byte);
    end

    out_valid_d  = emit || stall;
    out_bytes_d  = emit ? cnt_after : (stall ? out_bytes_q : 3'd0);
    cnt_d        = emit ? 2'd0 : cnt_after[1:0];
    word_count_d = word_count_q + CNT_W'(hs);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbuf_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_bytes_q  <= '0;
      word_count_q <= '0;
    end else begin
      wbuf_q       <= wbuf_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_bytes_q  <= out_bytes_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed vectors plus a queue-based reference model for
// two packer instances (big-endian with 16-bit count, little-endian with a
// 2-bit count so the counter wraps).
module tb_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        flush;
  logic        out_ready;

  logic        in_ready_be, out_valid_be;
  logic [31:0] out_word_be;
  logic [2:0]  out_bytes_be;
  logic [15:0] word_count_be;

  logic        in_ready_le, out_valid_le;
  logic [31:0] out_word_le;
  logic [2:0]  out_bytes_le;
  logic [1:0]  word_count_le;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // reference model state
  byte unsigned q[$];
  byte unsigned held[4];
  int           m_n = 0;
  bit           m_pend = 1'b0;
  int unsigned  m_count = 0;

  word_packer #(.BIG_ENDIAN(1), .CNT_W(16)) dut_be (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready_be), .flush(flush), .out_valid(out_valid_be),
    .out_ready(out_ready), .out_word(out_word_be), .out_bytes(out_bytes_be),
    .word_count(word_count_be));

  word_packer #(.BIG_ENDIAN(0), .CNT_W(2)) dut_le (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready_le), .flush(flush), .out_valid(out_valid_le),
    .out_ready(out_ready), .out_word(out_word_le), .out_bytes(out_bytes_le),
    .word_count(word_count_le));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input bit be);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (be) w = w | (32'(held[k]) << (24 - 8*k));
      else    w = w | (32'(held[k]) << (8*k));
    end
    return w;
  endfunction

  // Model: bytes queue up in arrival order; four of them, or a flush with
  // any pending, become one output word that waits for out_ready.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_pend  = 1'b0;
        m_n     = 0;
        m_count = 0;
        for (int k = 0; k < 4; k++) held[k] = 8'h00;
      end else begin
        bit rdy;
        rdy = !m_pend || out_ready;
        if (m_pend && out_ready) begin
          m_pend = 1'b0;
          m_count++;
        end
        if (rdy && in_valid) q.push_back(in_byte);
        if (q.size() == 4 || (rdy && flush && q.size() != 0)) begin
          m_n = q.size();
          for (int k = 0; k < 4; k++) held[k] = (k < m_n) ? q[k] : 8'h00;
          q.delete();
          m_pend = 1'b1;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic exp_rdy;
        exp_rdy = !m_pend || out_ready;
        chk("be_in_ready", 32'(in_ready_be), 32'(exp_rdy));
        chk("le_in_ready", 32'(in_ready_le), 32'(exp_rdy));
        chk("be_out_valid", 32'(out_valid_be), 32'(m_pend));
        chk("le_out_valid", 32'(out_valid_le), 32'(m_pend));
        chk("be_out_bytes", 32'(out_bytes_be), m_pend ? 32'(m_n) : 32'd0);
        chk("le_out_bytes", 32'(out_bytes_le), m_pend ? 32'(m_n) : 32'd0);
        chk("be_word_count", 32'(word_count_be), m_count & 32'hFFFF);
        chk("le_word_count", 32'(word_count_le), m_count & 32'h3);
        if (m_pend) begin
          chk("be_out_word", out_word_be, exp_word(1'b1));
          chk("le_out_word", out_word_le, exp_word(1'b0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready_be && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck 0, byte 0x%02h", b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wc0;
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid_be), 32'd0);
    chk("rst_out_word", out_word_be, 32'd0);
    chk("rst_out_bytes", 32'(out_bytes_be), 32'd0);
    chk("rst_word_count", 32'(word_count_be), 32'd0);
    rst_n = 1'b1;

    // 1: four back-to-back bytes, out_ready held high
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    chk("t1_valid", 32'(out_valid_be), 32'd1);
    chk("t1_word_be", out_word_be, 32'h10203040);
    chk("t1_word_le", out_word_le, 32'h40302010);
    chk("t1_bytes", 32'(out_bytes_be), 32'd4);
    tick();
    chk("t1_valid_drop", 32'(out_valid_be), 32'd0);
    chk("t1_count", 32'(word_count_be), 32'd1);

    // 2: consumer stalls, producer holds 0x50 until released
    wc0 = word_count_be;
    out_ready = 1'b0;
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    chk("t2_ready_low", 32'(in_ready_be), 32'd0);
    in_valid = 1'b1; in_byte = 8'h50;
    repeat (5) begin
      tick();
      chk("t2_hold_ready", 32'(in_ready_be), 32'd0);
      chk("t2_hold_word", out_word_be, 32'h10203040);
      chk("t2_hold_bytes", 32'(out_bytes_be), 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("t2_ready_comb", 32'(in_ready_be), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t2_count1", 32'(word_count_be), 32'(wc0 + 16'd1));
    send(8'h60); send(8'h70); send(8'h80);
    chk("t2_word2", out_word_be, 32'h50607080);
    tick();
    chk("t2_count2", 32'(word_count_be), 32'(wc0 + 16'd2));

    // 3: partial word via flush
    send(8'hAB); send(8'hCD);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_word_be", out_word_be, 32'hABCD0000);
    chk("t3_word_le", out_word_le, 32'h0000CDAB);
    chk("t3_bytes", 32'(out_bytes_be), 32'd2);
    tick();

    // 4: byte+flush with empty buffer, then flush alone
    in_valid = 1'b1; in_byte = 8'h11; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("t4_word_be", out_word_be, 32'h11000000);
    chk("t4_word_le", out_word_le, 32'h00000011);
    chk("t4_bytes", 32'(out_bytes_be), 32'd1);
    tick();
    wc0 = word_count_be;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_noop_valid", 32'(out_valid_be), 32'd0);
    tick();
    chk("t4_noop_count", 32'(word_count_be), 32'(wc0));

    // 5: flush arriving with the completing 4th byte
    send(8'h01); send(8'h02); send(8'h03);
    in_valid = 1'b1; in_byte = 8'h44; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("t5_valid", 32'(out_valid_be), 32'd1);
    chk("t5_bytes", 32'(out_bytes_be), 32'd4);
    chk("t5_word", out_word_be, 32'h01020344);
    tick();
    chk("t5_no_extra1", 32'(out_valid_be), 32'd0);
    tick();
    chk("t5_no_extra2", 32'(out_valid_be), 32'd0);

    // 6: reset discards partial bytes
    send(8'h55); send(8'h66);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_rst_valid", 32'(out_valid_be), 32'd0);
    chk("t6_rst_word", out_word_be, 32'd0);
    chk("t6_rst_bytes", 32'(out_bytes_be), 32'd0);
    chk("t6_rst_count", 32'(word_count_be), 32'd0);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("t6_word", out_word_be, 32'hDEADBEEF);
    chk("t6_word_le", out_word_le, 32'hEFBEADDE);
    tick();
    chk("t6_count", 32'(word_count_be), 32'd1);

    // mixed traffic with random back-pressure, checked by the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_byte   = 8'($urandom_range(0, 255));
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
